uart_mem_controller: RTL and testbench

//   Byte-command engine between a UART (rx strobe/byte, tx request/busy) and an internal byte RAM.

---
 rtl/uart_mem_controller.sv | 100 ++++++++++
 tb/tb_uart_mem_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_mem_controller.sv
// Byte-command engine: parses WRITE/READ block commands from a UART and moves data to/from a byte RAM.
// Read bytes go out one at a time, each gated on the UART tx busy flag, with a guard cycle between sends.
`ifndef COMMAND_WRITE
`define COMMAND_WRITE 8'h01
`endif
`ifndef COMMAND_READ
`define COMMAND_READ 8'h02
`endif

module uart_mem_controller #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte
);

  typedef enum logic [2:0] {
    IDLE, GET_LEN, GET_AHI, GET_ALO, WR_DATA, RD_FETCH, RD_SEND, RD_WAIT
  } state_t;

  state_t                  state, state_next;
  logic                    cmd_read;
  logic [7:0]              len;
  logic [7:0]              addr_hi;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [7:0]              rd_data;
  logic [7:0]              mem [0:(1<<ADDR_WIDTH)-1];

  logic mem_we, send, addr_inc, len_dec;

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    send       = 1'b0;
    addr_inc   = 1'b0;
    len_dec    = 1'b0;
    case (state)
      IDLE: if (received && (rx_byte == `COMMAND_WRITE || rx_byte == `COMMAND_READ))
              state_next = GET_LEN;
      GET_LEN: if (received) state_next = GET_AHI;
      GET_AHI: if (received) state_next = GET_ALO;
      GET_ALO: if (received) state_next = cmd_read ? RD_FETCH : WR_DATA;
      WR_DATA: if (received) begin
        mem_we   = 1'b1;
        addr_inc = 1'b1;
        if (len == 8'd0) state_next = IDLE;
        else             len_dec = 1'b1;
      end
      RD_FETCH: state_next = RD_SEND;
      RD_SEND: if (!is_transmitting) begin
        send       = 1'b1;
        addr_inc   = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        // Guard cycle: the UART busy flag only rises a cycle after our request.
        if (len == 8'd0) state_next = IDLE;
        else begin
          len_dec    = 1'b1;
          state_next = RD_FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cmd_read <= 1'b0;
      len      <= 8'd0;
      addr_hi  <= 8'd0;
      addr     <= '0;
      transmit <= 1'b0;
      tx_byte  <= 8'd0;
    end else begin
      state    <= state_next;
      transmit <= send;
      if (send) tx_byte <= rd_data;
      if (state == IDLE && received) cmd_read <= (rx_byte == `COMMAND_READ);
      if (state == GET_LEN && received) len <= rx_byte;
      else if (len_dec) len <= len - 8'd1;
      if (state == GET_AHI && received) addr_hi <= rx_byte;
      // Upper address bits beyond ADDR_WIDTH are dropped by the cast.
      if (state == GET_ALO && received) addr <= ADDR_WIDTH'({addr_hi, rx_byte});
      else if (addr_inc) addr <= addr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[addr] <= rx_byte;
    rd_data <= mem[addr];
  end

endmodule

// File: tb/tb_uart_mem_controller.sv
// Scoreboarded bench: stimulus pushes expected tx bytes, a monitor pops and compares on each transmit pulse.
`ifndef COMMAND_WRITE
`define COMMAND_WRITE 8'h01
`endif
`ifndef COMMAND_READ
`define COMMAND_READ 8'h02
`endif

module tb_uart_mem_controller;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       received = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       is_transmitting = 1'b0;
  logic       transmit;
  logic [7:0] tx_byte;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  logic prev_tx = 1'b0;
  logic [7:0] exp_q[$];

  uart_mem_controller #(.ADDR_WIDTH(12)) dut (
    .clock(clock), .reset(reset), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte)
  );

  always #5 clock = ~clock;

  // Monitor: sampled mid-cycle, well away from the rising edge.
  always @(negedge clock) begin
    if (transmit === 1'b1) begin
      logic [7:0] e;
      pulses++;
      tests++;
      if (prev_tx !== 1'b0) begin
        fails++;
        $display("FAIL back_to_back: transmit high on consecutive cycles (tx_byte=%02h)", tx_byte);
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_tx: got %02h, none expected", tx_byte);
      end else begin
        e = exp_q.pop_front();
        if (tx_byte !== e) begin
          fails++;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_byte, e);
        end
      end
    end
    prev_tx = transmit;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clock);
    received = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send_byte(a); send_byte(b); send_byte(c); send_byte(d);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d bytes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(negedge clock);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clock);
    check("reset_transmit", {31'd0, transmit}, 32'd0);
    check("reset_tx_byte", {24'd0, tx_byte}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Basic write then read back
    send4(`COMMAND_WRITE, 8'h02, 8'h0E, 8'hCD);
    send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
    exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    send4(`COMMAND_READ, 8'h02, 8'h0E, 8'hCD);
    drain("read_0ecd");
    check("tx_byte_hold", {24'd0, tx_byte}, 32'h44);

    // Second block, then confirm the first one survived
    send4(`COMMAND_WRITE, 8'h02, 8'h0A, 8'h10);
    send_byte(8'h44); send_byte(8'h45); send_byte(8'h46);
    exp_q.push_back(8'h44); exp_q.push_back(8'h45); exp_q.push_back(8'h46);
    send4(`COMMAND_READ, 8'h02, 8'h0A, 8'h10);
    drain("read_0a10");
    exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    send4(`COMMAND_READ, 8'h02, 8'h0E, 8'hCD);
    drain("reread_0ecd");

    // UART busy holds off transmission
    is_transmitting = 1'b1;
    p0 = pulses;
    exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    send4(`COMMAND_READ, 8'h02, 8'h0E, 8'hCD);
    repeat (5) @(negedge clock);
    check("busy_no_tx", pulses - p0, 32'd0);
    is_transmitting = 1'b0;
    drain("read_after_busy");

    // Unknown command ignored
    send_byte(8'h7F);
    exp_q.push_back(8'h42);
    send4(`COMMAND_READ, 8'h00, 8'h0E, 8'hCD);
    drain("read_after_unknown");

    // Address wrap at top of RAM
    send4(`COMMAND_WRITE, 8'h01, 8'h0F, 8'hFF);
    send_byte(8'hAA); send_byte(8'hBB);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    send4(`COMMAND_READ, 8'h01, 8'h0F, 8'hFF);
    drain("read_wrap");
    exp_q.push_back(8'hBB);
    send4(`COMMAND_READ, 8'h00, 8'h00, 8'h00);
    drain("read_addr0");

    // Reset mid-write: following byte is a command, not data
    send4(`COMMAND_WRITE, 8'h00, 8'h0E, 8'hCD);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset_transmit", {31'd0, transmit}, 32'd0);
    check("midreset_tx_byte", {24'd0, tx_byte}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    send_byte(8'h99);
    exp_q.push_back(8'h42);
    send4(`COMMAND_READ, 8'h00, 8'h0E, 8'hCD);
    drain("read_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
